// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: one-outstanding imem reader feeding a DEPTH-entry {instr, pc, pc+4} queue.
// Entry visible one cycle after rvalid; stops requesting while full, head held until out_ready.
module fetch_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_gnt,
  input  logic                         imem_rvalid,
  input  logic [INSTR_W-1:0]           imem_rdata,
  output logic                         out_valid,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [ADDR_W-1:0]            out_pc4,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   req_pc;
  logic [INSTR_W-1:0]  q_instr [DEPTH];
  logic [ADDR_W-1:0]   q_pc    [DEPTH];
  logic [ADDR_W-1:0]   q_pc4   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [OCC_W-1:0]    occ;

  logic                full;
  logic                push;
  logic                pop;
  logic                accept;
  logic [ADDR_W-1:0]   redirect_aligned;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign full     = (occ == OCC_W'(DEPTH));
  // The single outstanding response always has a free slot because we only issue below DEPTH.
  assign imem_req = !rst && (state == IDLE) && !redirect && !full;
  assign accept   = imem_req && imem_gnt;
  assign push     = (state == WAIT) && imem_rvalid && !redirect;
  assign pop      = out_valid && out_ready && !redirect;

  assign imem_addr = pc;
  assign occupancy = occ;
  assign out_valid = (occ != '0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];
  assign out_pc4   = q_pc4[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_pc4[i]   <= '0;
      end
    end else begin
      if (redirect) begin
        pc <= redirect_aligned;
      end else if (accept) begin
        pc     <= pc + ADDR_W'(4);
        req_pc <= pc;
      end

      // A redirect with the response in flight must swallow that response later.
      case (state)
        IDLE:    if (accept) state <= WAIT;
        WAIT:    if (imem_rvalid) state <= IDLE;
                 else if (redirect) state <= DROP;
        DROP:    if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) begin
          assert (!full);
          q_instr[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]    <= req_pc;
          q_pc4[wr_ptr]   <= req_pc + ADDR_W'(4);
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule
